// File: rtl/pca_pkg.sv
// ============================================================================
// pca_pkg : shared types and default sizes for the PCA result path
// Rev 1.0
// ============================================================================
`default_nettype none

package pca_pkg;

    localparam int MATRIX_SIZE_DEF = 4;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int MAT_ELEMS       = MATRIX_SIZE_DEF * MATRIX_SIZE_DEF;
    localparam int ROW_BITS        = MATRIX_SIZE_DEF * DATA_WIDTH_DEF;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } collector_state_t;

endpackage

`default_nettype wire

// File: rtl/unpacked_packed_converter.sv
// ============================================================================
// unpacked_packed_converter : flattens an element array into one packed word
// Rev 1.0
// ============================================================================
`default_nettype none

module unpacked_packed_converter
    import pca_pkg::*;
#(
    parameter int ELEMS      = MAT_ELEMS,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0]       unpacked_data [ELEMS],
    output logic [ELEMS*DATA_WIDTH-1:0] packed_data
);

    // Element i lands in slice i, so element 0 occupies the least significant bits.
    for (genvar i = 0; i < ELEMS; i++) begin : g_elem
        assign packed_data[i*DATA_WIDTH +: DATA_WIDTH] = unpacked_data[i];
    end

endmodule

`default_nettype wire

// File: rtl/tpu_result_collector.sv
// ============================================================================
// tpu_result_collector : gathers TPU rows into a matrix and hands it downstream
// Rev 1.0
// ============================================================================
`default_nettype none

module tpu_result_collector
    import pca_pkg::*;
#(
    parameter  int MATRIX_SIZE = 4,
    parameter  int DATA_WIDTH  = 8,
    parameter  int CNT_WIDTH   = 16,
    localparam int IDX_W       = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush,
    input  logic                                      row_valid,
    output logic                                      row_ready,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0]         row_data,
    output logic                                      mat_valid,
    input  logic                                      mat_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_data,
    output logic [IDX_W-1:0]                          row_idx,
    output logic [CNT_WIDTH-1:0]                      mat_count
);

    localparam int               N_ELEMS  = MATRIX_SIZE * MATRIX_SIZE;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(MATRIX_SIZE - 1);

    collector_state_t      state;
    collector_state_t      state_next;
    logic                  accept;
    logic                  handshake;
    logic                  last_row;
    logic [DATA_WIDTH-1:0] buffer [N_ELEMS];

    // flush masks both accept and handshake so it wins over either event.
    always_comb begin
        state_next = state;
        row_ready  = (state == COLLECT);
        mat_valid  = (state == FULL);
        last_row   = (row_idx == LAST_ROW);
        accept     = row_valid && row_ready && !flush;
        handshake  = mat_valid && mat_ready && !flush;
        if (flush) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (accept && last_row) state_next = FULL;
                FULL:    if (handshake)          state_next = COLLECT;
                default:                         state_next = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx   <= '0;
            mat_count <= '0;
        end else begin
            if (flush)       row_idx <= '0;
            else if (accept) row_idx <= last_row ? '0 : row_idx + IDX_W'(1);
            if (handshake)   mat_count <= mat_count + CNT_WIDTH'(1);
        end
    end

    // Stale rows from the previous matrix are simply overwritten on refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEMS; i++) buffer[i] <= '0;
        end else if (accept) begin
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                if (row_idx == IDX_W'(r)) begin
                    for (int c = 0; c < MATRIX_SIZE; c++)
                        buffer[r*MATRIX_SIZE + c] <= row_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    unpacked_packed_converter #(
        .ELEMS      (N_ELEMS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_conv (
        .unpacked_data (buffer),
        .packed_data   (mat_data)
    );

endmodule

`default_nettype wire

// File: doc/tpu_result_collector.md
Name: tpu_result_collector

Overview:
- Collects TPU result rows, streamed one row per beat, into an internal MATRIX_SIZE x MATRIX_SIZE element buffer.
- When the buffer holds a full matrix, it presents the matrix to downstream PCA stages as one packed word over a valid/ready handshake.
- It sits between the TPU output and the covariance/eigen stages.
- It owns the sequencing that the purely combinational unpacked-to-packed alignment cannot do.

Parameters:
- MATRIX_SIZE, 4, matrix dimension: rows per matrix and elements per row.
- DATA_WIDTH, 8, bits per element.
- CNT_WIDTH, 16, width of the delivered-matrix counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; discards any partial or pending matrix.
- row_valid  input  1  TPU row beat valid.
- row_ready  output  1  collector can accept a row this cycle.
- row_data  input  MATRIX_SIZE*DATA_WIDTH  one row; element c at bits [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH].
- mat_valid  output  1  full packed matrix available.
- mat_ready  input  1  downstream accepts the matrix.
- mat_data  output  MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH  packed matrix; element i = r*MATRIX_SIZE+c at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- row_idx  output  $clog2(MATRIX_SIZE)  index of the next row slot to be written.
- mat_count  output  CNT_WIDTH  number of matrices delivered since reset; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=COLLECT, row_idx=0, mat_valid=0, mat_count=0.
  - All buffer elements=0, so mat_data=0.
  - row_ready=1 once rst_n deasserts.
- States:
  - COLLECT: row_ready=1, mat_valid=0.
  - FULL: row_ready=0, mat_valid=1.
- Row accept:
  - Accept occurs when row_valid && row_ready at a rising edge.
  - row_data is written to buffer row row_idx.
  - row_idx increments.
- COLLECT -> FULL:
  - Taken on an accept with row_idx==MATRIX_SIZE-1; row_idx wraps to 0.
  - If the last row is accepted at edge t, mat_valid is high from t until the handshake.
  - mat_data already contains that last row in the same cycle (1-cycle latency, registered).
- FULL -> COLLECT:
  - Taken on mat_valid && mat_ready at an edge; mat_count increments by 1, with wrap.
  - row_ready returns to 1 in the next cycle, so there is one bubble per matrix.
  - No overlap of drain and fill.
- While in FULL:
  - mat_data is stable until the handshake completes.
  - row_valid is ignored; no write and no state change.
- While in COLLECT: mat_ready is ignored.
- mat_data is driven combinationally from the buffer and is meaningful only while mat_valid=1.
- Buffer contents are not cleared after a handshake; stale data is overwritten row by row.
- flush=1 at an edge:
  - Sets state=COLLECT, row_idx=0, mat_valid=0.
  - Leaves buffer contents and mat_count unchanged.
  - Has priority over a simultaneous row accept (row discarded) and over a simultaneous mat handshake (mat_count NOT incremented).
  - row_ready stays as defined by state; a row presented in the flush cycle is not accepted.
- Reset asserted mid-matrix or mid-drain: immediate return to reset values; no partial matrix is ever emitted.
- MATRIX_SIZE=1 is legal: every accepted row goes directly to FULL.

Decomposition:
- Shared package pca_pkg holds:
  - Localparams MAT_ELEMS = MATRIX_SIZE*MATRIX_SIZE and ROW_BITS = MATRIX_SIZE*DATA_WIDTH.
  - typedef enum logic {COLLECT, FULL} collector_state_t.
- One sub-module is natural: the existing unpacked_packed_converter.
  - It is instantiated on the element buffer (unpacked array of MAT_ELEMS elements) to produce mat_data.
  - The collector itself only sequences and stores.

Test Plan:
- Reset then 4 back-to-back rows:
  - Stimulus: row r holds elements {r*4+c+1}, i.e. row0 = 0x04030201.
  - Required response: mat_valid rises 1 cycle after the 4th accept; mat_data = 0x100F0E0D_0C0B0A09_08070605_04030201; row_ready=0 while FULL.
- Backpressure:
  - Stimulus: hold mat_ready=0 for 10 cycles while row_valid=1 with new data.
  - Required response: mat_data unchanged, no row accepted, row_idx=0; mat_ready=1 gives mat_count=1 and row_ready=1 the next cycle.
- Gapped input:
  - Stimulus: row_valid toggling 1/0.
  - Required response: row_idx advances only on accept edges; the matrix is identical to the back-to-back case.
- Flush:
  - Flush after 2 rows: row_idx returns to 0, no mat_valid; 4 fresh rows are then needed.
  - Flush coinciding with a mat handshake: mat_valid=0 afterwards, mat_count unchanged.
- Async reset mid-drain:
  - Stimulus: rst_n low asynchronously (between edges) while mat_valid=1.
  - Required response: mat_valid, row_idx and mat_count go to 0 immediately; mat_data=0.
- Counter wrap:
  - Setup: CNT_WIDTH=2.
  - Stimulus: deliver 5 matrices.
  - Required response: mat_count sequence 1,2,3,0,1.
